// File: rtl/conv_stream_pkg.sv
// Shared widths, default frame length and FSM encoding
// for the convolution result streamer.
package conv_stream_pkg;

    localparam int DEF_DW = 16;
    localparam int DEF_N  = 2420;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/conv_result_streamer_if.sv
// Valid/ready sample stream carrying data, index and last flag.
interface conv_stream_if #(
    parameter int DW = 16,
    parameter int IW = 12
);
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_index;
    logic          m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/conv_result_streamer_peak.sv
// Running peak of saturated |sample| over one frame.
module conv_peak_tracker
    import conv_stream_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          update,
    input  logic [DW-1:0] sample,
    output logic [DW-1:0] peak_next
);

    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MOST_POS = {1'b0, {(DW-1){1'b1}}};

    logic [DW-1:0] peak_q;
    logic [DW-1:0] mag;

    // -2^(DW-1) has no positive twin, so it clamps to the max positive
    always_comb begin
        mag = sample;
        if (sample == MOST_NEG) begin
            mag = MOST_POS;
        end else if (sample[DW-1]) begin
            mag = ~sample + DW'(1);
        end
    end

    always_comb begin
        peak_next = peak_q;
        if (update && (mag > peak_q)) begin
            peak_next = mag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else if (clear) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_next;
        end
    end

endmodule

// File: rtl/conv_result_streamer.sv
// Captures a finished convolution frame and streams it out
// one sample per handshake, reporting the frame's peak |x|.
module conv_result_streamer
    import conv_stream_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int N  = DEF_N
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            conv_done,
    input  logic [N*DW-1:0] conv_data,
    conv_stream_if.master   m,
    output logic            busy,
    output logic [DW-1:0]   peak_abs,
    output logic            frame_done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t        state_q;
    state_t        state_d;
    logic          cd_q;
    logic          cd_rise;
    logic          capture;
    logic          hs;
    logic          last_hs;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_nxt;
    logic [DW-1:0] data_q;
    logic [DW-1:0] peak_next;
    logic [DW-1:0] smp_q [N];

    always_comb begin
        cd_rise = conv_done & ~cd_q;
        capture = (state_q == IDLE) & cd_rise;
        hs      = (state_q == STREAM) & m.m_ready;
        last_hs = hs & (idx_q == LAST);
        idx_nxt = idx_q + IW'(1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (capture) state_d = STREAM;
            STREAM:  if (last_hs) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame store is pure data; only the control path needs reset
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < N; i++) begin
                smp_q[i] <= conv_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_q     <= 1'b0;
            idx_q    <= '0;
            data_q   <= '0;
            peak_abs <= '0;
        end else begin
            cd_q <= conv_done;
            if (capture) begin
                idx_q  <= '0;
                data_q <= conv_data[DW-1:0];
            end else if (hs && !last_hs) begin
                idx_q  <= idx_nxt;
                data_q <= smp_q[idx_nxt];
            end
            if (last_hs) begin
                peak_abs <= peak_next;
            end
        end
    end

    conv_peak_tracker #(
        .DW (DW)
    ) u_peak (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (capture),
        .update    (hs),
        .sample    (data_q),
        .peak_next (peak_next)
    );

    assign m.m_valid  = (state_q == STREAM);
    assign m.m_data   = data_q;
    assign m.m_index  = idx_q;
    assign m.m_last   = (state_q == STREAM) && (idx_q == LAST);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule

// File: doc/conv_result_streamer.md
CONV_RESULT_STREAMER -- requirements
Module: conv_result_streamer

Interface
REQ-001 SHALL have parameter DW, default 16: signed sample width, two's complement.
REQ-002 SHALL have parameter N, default 2420: number of convolution result samples per frame (filter length 20 + signal length 2401 - 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port conv_done, input, 1 bit: level completion flag from the upstream convolver.
REQ-006 SHALL have port conv_data, input, N*DW bits: flattened results, sample i at [i*DW +: DW].
REQ-007 SHALL have port m_ready, input, 1 bit: downstream accepts the current sample.
REQ-008 SHALL have port m_valid, output, 1 bit: m_data holds a valid sample.
REQ-009 SHALL have port m_data, output, DW bits: current sample.
REQ-010 SHALL have port m_index, output, clog2(N) bits: index of the current sample.
REQ-011 SHALL have port m_last, output, 1 bit: the current sample is index N-1.
REQ-012 SHALL have port busy, output, 1 bit: a frame is captured or streaming.
REQ-013 SHALL have port peak_abs, output, DW bits: largest |sample| of the last completed frame.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the final handshake.

Function
REQ-015 SHALL implement FSM states IDLE, STREAM and DONE.
REQ-016 SHALL register conv_done each cycle and detect its rising edge (conv_done=1, previous=0).
REQ-017 SHALL, in IDLE on a rising edge, capture all N samples of conv_data into an internal buffer, clear the index to 0, clear the running peak to 0, and enter STREAM.
REQ-018 SHALL assert m_valid from the cycle after capture, so the first sample is presented with 1-cycle latency.
REQ-019 SHALL define a handshake as m_valid and m_ready both high at a rising clk edge.
REQ-020 SHALL hold m_data, m_index and m_last stable while m_valid=1 and m_ready=0.
REQ-021 SHALL advance the index by 1 on each handshake, sustaining one sample per cycle when m_ready is held high.
REQ-022 SHALL assert m_last only when m_index = N-1.
REQ-023 SHALL, on each handshake, update the running peak to max(running peak, |m_data|).
REQ-024 SHALL compute |x| saturated to 2^(DW-1)-1, so |-32768| = 32767 for DW=16.
REQ-025 SHALL, on the handshake with m_last=1, deassert m_valid the next cycle and enter DONE.
REQ-026 SHALL, in DONE, pulse frame_done for exactly one cycle, copy the running peak to peak_abs in the same cycle, and return to IDLE.
REQ-027 SHALL hold peak_abs until the next DONE.
REQ-028 SHALL ignore conv_done edges while in STREAM or DONE.
REQ-029 SHALL require conv_done to fall and rise again before accepting a new frame; a level held high does not retrigger.
REQ-030 SHALL assert busy in STREAM and DONE only.
REQ-031 SHALL allow conv_data to change freely after the capture cycle.

Reset
REQ-032 SHALL, on rst_n low (asynchronous, at any time, including mid-frame), force: state IDLE, m_valid 0, m_data 0, m_index 0, m_last 0, busy 0, frame_done 0, peak_abs 0, edge register 0.
REQ-033 SHALL resume from IDLE after rst_n deasserts; a conv_done already high then counts as a rising edge.

Structure
REQ-034 SHALL place DW, the default N and the state encoding in a shared package, conv_stream_pkg.
REQ-035 SHALL implement the saturating |x| and the max compare in one sub-module, conv_peak_tracker.

Verification
REQ-036 SHALL verify, with N=4, data {5,-3,100,-32768}, m_ready=1 and a conv_done rising edge: m_valid is high for exactly 4 cycles starting 1 cycle after the edge, m_index runs 0..3, m_last is high only on -32768, frame_done pulses once, and peak_abs=32767.
REQ-037 SHALL verify backpressure, with m_ready=0 on cycles 2-4 of the stream: m_data, m_index and m_last stay constant, and there are no lost or duplicated samples (4 handshakes total).
REQ-038 SHALL verify, with conv_data changed to all-zero after capture: the streamed values remain the captured ones, and peak_abs=100 for data {5,-3,100,7}.
REQ-039 SHALL verify that conv_done held high through frame_done and beyond produces no second frame, and that a low-then-high toggle starts a new frame.
REQ-040 SHALL verify that rst_n pulsed low at index 2: m_valid drops asynchronously, peak_abs=0, busy=0, and the next conv_done edge restarts streaming at index 0.
